prv32_divider: RTL and testbench
================================

// Module: prv32_divider
// PURPOSE
//  Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for the execute stage.
//  Sits beside prv32 ALU; takes the same rs1/rs2 operands; stalls issue via in_ready/out_valid.
//  Radix-2 restoring division, one quotient bit per cycle, valid/ready handshake both sides.
// PARAMETERS
//  XLEN   32   operand/result width; counter width = $clog2(XLEN)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     operands/op valid
//  in_ready   out  1     unit idle, can accept
//  a          in   XLEN  dividend (rs1)
//  b          in   XLEN  divisor (rs2)
//  op         in   2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  out_valid  out  1     r holds final result
//  out_ready  in   1     consumer takes result
//  r          out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
//  dz         out  1     result came from divide-by-zero case (valid with out_valid)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, r=0, dz=0, counter=0.
//  States: IDLE, CALC, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE: accept when in_valid&in_ready in cycle T; latch op, signs, |a|,|b| (abs only for
//   signed ops, DIV/REM); load counter=XLEN-1, remainder acc=0, quotient reg=|a|.
//   - b==0: skip CALC -> DONE; r = quotient? all-ones : a (unmodified); dz=1.
//   - signed op, a==0x8000_0000, b==all-ones: skip CALC -> DONE; r = DIV? 0x8000_0000 : 0.
//   - otherwise -> CALC.
//  CALC: each cycle shift {acc,q} left 1; if acc>=|b| (XLEN+1-bit compare) acc-=|b|, q[0]=1.
//   Counter decrements; step done with counter==0 -> DONE, loading r with sign-fixed result:
//   quotient negated if sign(a)^sign(b) (signed only); remainder negated if sign(a) (signed only).
//   Normal latency: out_valid first high in cycle T+XLEN+1; special cases: cycle T+1.
//  DONE: r, dz held stable while out_valid & !out_ready (no change under backpressure).
//   out_valid&out_ready -> IDLE next cycle; in_ready high next cycle (no same-cycle accept).
//  in_valid ignored outside IDLE; a/b/op need only be stable in the accept cycle.
//  Unsigned arithmetic internally in XLEN+1 bits; no |x| overflow since 0x8000_0000 magnitude
//   fits unsigned XLEN. Remainder sign always follows dividend; quotient truncates toward zero.
//  rst in any state (incl. mid-CALC or DONE under backpressure): return to reset values next
//   edge, operation discarded, no out_valid pulse.
//  dz cleared on every accept.
// TESTING
//  DIVU a=100 b=7, out_ready=1 -> out_valid at T+33, r=14, dz=0; in_ready back at T+34.
//  REM a=-7 (0xFFFFFFF9) b=2 -> r=0xFFFFFFFF (-1); DIV same operands -> r=0xFFFFFFFD (-3).
//  DIV a=5 b=0 -> out_valid at T+1, r=0xFFFFFFFF, dz=1; REMU a=5 b=0 -> r=5, dz=1.
//  DIV a=0x80000000 b=0xFFFFFFFF -> T+1, r=0x80000000; REM same -> r=0; DIVU same -> r=0, T+33.
//  DIVU 0xFFFFFFFF/1 with out_ready low 5 cycles after out_valid -> r=0xFFFFFFFF stable,
//   out_valid held, in_ready=0 throughout; completes on out_ready.
//  rst pulsed at T+10 of a DIV -> next cycle in_ready=1, out_valid=0, r=0; new DIVU 9/3 -> r=3.

Source files
------------

// File: rtl/prv32_divider.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) using radix-2 restoring division.
// Computes one quotient bit per cycle, with a valid/ready handshake on both the operand and result sides.
module prv32_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r,
  output logic            dz
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ZERO_WORD = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negate when neg is set; shared by the operand abs and the result sign fix.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
    logic [XLEN-1:0] res;
    if (neg) begin
      res = ~x + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      res = x;
    end
    return res;
  endfunction

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] q_r;
  logic [XLEN-1:0] babs_r;
  logic            is_rem_r;
  logic            neg_q_r;
  logic            neg_rem_r;

  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] aabs_s;
  logic [XLEN-1:0] babs_s;
  logic            bzero_s;
  logic            ovf_s;

  logic [XLEN:0]   acc_sh_s;
  logic [XLEN:0]   diff_s;
  logic [XLEN-1:0] acc_nxt_s;
  logic [XLEN-1:0] q_nxt_s;
  logic [XLEN-1:0] res_s;

  // Accept-cycle operand decode: signs, magnitudes and the two early-exit cases.
  always_comb begin
    a_neg_s = ~op[0] & a[XLEN-1];
    b_neg_s = ~op[0] & b[XLEN-1];
    aabs_s  = cond_neg(a, a_neg_s);
    babs_s  = cond_neg(b, b_neg_s);
    bzero_s = (b == ZERO_WORD);
    ovf_s   = ~op[0] & (a == INT_MIN) & (b == ALL_ONES);
  end

  // One restoring step plus the sign-fixed result used on the final step.
  always_comb begin
    acc_sh_s = {acc_r, q_r[XLEN-1]};
    diff_s   = acc_sh_s - {1'b0, babs_r};
    if (acc_sh_s >= {1'b0, babs_r}) begin
      acc_nxt_s = diff_s[XLEN-1:0];
      q_nxt_s   = {q_r[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt_s = acc_sh_s[XLEN-1:0];
      q_nxt_s   = {q_r[XLEN-2:0], 1'b0};
    end
    if (is_rem_r) begin
      res_s = cond_neg(acc_nxt_s, neg_rem_r);
    end else begin
      res_s = cond_neg(q_nxt_s, neg_q_r);
    end
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= ZERO_WORD;
      dz        <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= ZERO_WORD;
      q_r       <= ZERO_WORD;
      babs_r    <= ZERO_WORD;
      is_rem_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dz        <= 1'b0;
            is_rem_r  <= op[1];
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            babs_r    <= babs_s;
            acc_r     <= ZERO_WORD;
            q_r       <= aabs_s;
            cnt_r     <= CNT_LAST;
            in_ready  <= 1'b0;
            if (bzero_s) begin
              r         <= op[1] ? a : ALL_ONES;
              dz        <= 1'b1;
              out_valid <= 1'b1;
              state_r   <= DONE;
            end else if (ovf_s) begin
              r         <= op[1] ? ZERO_WORD : INT_MIN;
              out_valid <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r   <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= acc_nxt_s;
          q_r   <= q_nxt_s;
          if (cnt_r == {CW{1'b0}}) begin
            r         <= res_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            state_r <= CALC;
          end
        end
        DONE: begin
          // Result stays frozen until the consumer takes it; no same-cycle re-accept.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prv32_divider.sv
// Directed self-checking bench for prv32_divider: results, latency, divide-by-zero,
// signed overflow, backpressure and mid-operation reset.
module tb_prv32_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [1:0]  op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] r;
  logic        dz;

  int tests = 0;
  int fails = 0;
  int lat;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  prv32_divider #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single accept cycle, then count cycles until out_valid.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = 2'b01;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] er, input logic edz, input int elat);
    issue(o, x, y);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_r"}, r, er);
    check({tag, "_dz"}, {31'd0, dz}, {31'd0, edz});
    tick();
    check({tag, "_rdy_back"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_r", r, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);

    out_ready = 1'b1;
    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    run("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 33);
    run("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, 33);
    run("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33);
    run("rem_100_m7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b0, 33);
    run("remu_big", OP_REMU, 32'hFFFF_FFF9, 32'd10, 32'd9, 1'b0, 33);
    run("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    run("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    run("divu_ovf_pat", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);

    // Backpressure: result must hold while out_ready is low, new requests ignored.
    out_ready = 1'b0;
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    check("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
      tick();
      check("bp_r", r, 32'hFFFF_FFFF);
      check("bp_hold", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});

    // Reset pulsed mid-CALC discards the operation.
    op = OP_DIV; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_r", r, 32'd0);
    tick();
    check("midrst_no_pulse", {31'd0, out_valid}, 32'd0);
    run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
